rleenc_gen: RTL and testbench

Parametrised run-length encoder that scans one block of N = 2^LOG2N signed coefficients from a synchronous RAM and emits a DC term, (level, run) pairs and an end-of-block marker to the downstream Huffman/hash-table stage. It replaces the fixed 64-entry raster encoder in the MPEG2 pipeline. It adds configurable coefficient width and block depth, a run-time zigzag scan mode, and optional DC prediction.

---
 rtl/rleenc_gen_if.sv | 32 +++
 rtl/rleenc_gen.sv | 173 +++++++++++++++++
 tb/tb_rleenc_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rleenc_gen_if.sv
// rleenc_gen_if: bus bundle for the run-length encoder.
// Carries the start/scan controls, the coefficient RAM read port and the
// symbol stream towards the Huffman/hash-table stage.
// slave  : the encoder side.
// master : the controlling environment (start logic, RAM, symbol consumer).
interface rleenc_gen_if #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) ();
    logic                    en;
    logic                    zz;
    logic                    dc_clr;
    logic                    rdy;
    logic [LOG2N-1:0]        addr;
    logic signed [WIDTH-1:0] q;
    logic                    h_rdy;
    logic                    h_en;
    logic signed [WIDTH-1:0] h_val;
    logic [LOG2N-1:0]        h_len;
    logic                    h_dc;
    logic                    h_end;

    modport slave (
        input  en, zz, dc_clr, q, h_rdy,
        output rdy, addr, h_en, h_val, h_len, h_dc, h_end
    );

    modport master (
        output en, zz, dc_clr, q, h_rdy,
        input  rdy, addr, h_en, h_val, h_len, h_dc, h_end
    );
endinterface

// File: rtl/rleenc_gen.sv
// rleenc_gen: run-length encoder for one block of 2^LOG2N signed coefficients.
// Reads the block from a synchronous RAM (one edge read latency) in raster or
// 8x8 zigzag order and emits a DC symbol, (level, run) pairs and an end marker.
// Optional feature macro: RLEENC_DCPRED_EN enables DC prediction (the DC symbol
// carries the difference to the previous block's raw DC coefficient).
module rleenc_gen #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    rleenc_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, EOB} state_t;

    localparam logic [LOG2N-1:0] KLAST = '1;
    localparam logic [LOG2N-1:0] ONE   = LOG2N'(1);
    localparam logic [LOG2N-1:0] TWO   = LOG2N'(2);

    // Standard MPEG-2/JPEG 8x8 zigzag scan order.
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t                  state;
    logic [LOG2N-1:0]        k;
    logic [LOG2N-1:0]        run;
    logic                    zz_lat;
    logic signed [WIDTH-1:0] pend_val;
    logic [LOG2N-1:0]        pend_len;
    logic                    pend_dc;
    logic signed [WIDTH-1:0] dc_val;
    logic signed [WIDTH-1:0] sym_val;
    logic [LOG2N-1:0]        sym_len;
    logic                    is_dc;
    logic                    sym_found;

    // Scan index to RAM address; zigzag only exists for the 8x8 block size.
    function automatic logic [LOG2N-1:0] map_idx(input logic [LOG2N-1:0] i,
                                                 input logic zmode);
        if (LOG2N == 6 && zmode) return LOG2N'(ZZ_ROM[6'(i)]);
        return i;
    endfunction

    assign is_dc     = (k == '0);
    assign sym_found = is_dc || (bus.q != '0);
    assign sym_val   = is_dc ? dc_val : bus.q;
    assign sym_len   = is_dc ? '0 : run;

`ifdef RLEENC_DCPRED_EN
    logic signed [WIDTH-1:0] pred;

    // DC predictor: cleared from idle on dc_clr, reloaded with each raw DC coefficient
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pred <= '0;
        else if (state == IDLE && bus.dc_clr)
            pred <= '0;
        else if (state == EVAL && is_dc)
            pred <= bus.q;
    end

    assign dc_val = bus.q - pred;
`else
    logic unused_dc_clr;
    assign unused_dc_clr = bus.dc_clr;
    assign dc_val        = bus.q;
`endif

    // Pending symbol, kept while the consumer holds h_rdy low
    always_ff @(posedge clk) begin
        if (state == EVAL && sym_found) begin
            pend_val <= sym_val;
            pend_len <= sym_len;
            pend_dc  <= is_dc;
        end
    end

    // Scan FSM: address generation, run counting and registered symbol strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bus.rdy  <= 1'b1;
            bus.addr <= '0;
            bus.h_en <= 1'b0;
            bus.h_val <= '0;
            bus.h_len <= '0;
            bus.h_dc  <= 1'b0;
            bus.h_end <= 1'b0;
            k        <= '0;
            run      <= '0;
            zz_lat   <= 1'b0;
        end else begin
            // Symbol fields read as zero outside a strobe.
            bus.h_en  <= 1'b0;
            bus.h_val <= '0;
            bus.h_len <= '0;
            bus.h_dc  <= 1'b0;
            bus.h_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        zz_lat   <= bus.zz;
                        k        <= '0;
                        run      <= '0;
                        bus.addr <= map_idx('0, bus.zz);
                        bus.rdy  <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // RAM is reading map(0); run the address one index ahead from here on.
                    bus.addr <= map_idx(k + ONE, zz_lat);
                    state    <= EVAL;
                end
                EVAL: begin
                    if (sym_found) begin
                        if (bus.h_rdy) begin
                            bus.h_en  <= 1'b1;
                            bus.h_val <= sym_val;
                            bus.h_len <= sym_len;
                            bus.h_dc  <= is_dc;
                        end
                        run   <= '0;
                        state <= EMIT;
                    end else begin
                        run <= run + ONE;
                        if (k == KLAST) begin
                            state <= EOB;
                        end else begin
                            k        <= k + ONE;
                            bus.addr <= map_idx(k + TWO, zz_lat);
                        end
                    end
                end
                EMIT: begin
                    if (bus.h_en) begin
                        // Strobe cycle: h_rdy is ignored here, then the scan resumes.
                        if (k == KLAST) begin
                            state <= EOB;
                        end else begin
                            k        <= k + ONE;
                            bus.addr <= map_idx(k + TWO, zz_lat);
                            state    <= EVAL;
                        end
                    end else if (bus.h_rdy) begin
                        bus.h_en  <= 1'b1;
                        bus.h_val <= pend_val;
                        bus.h_len <= pend_len;
                        bus.h_dc  <= pend_dc;
                    end
                end
                EOB: begin
                    if (bus.h_en) begin
                        bus.rdy <= 1'b1;
                        state   <= IDLE;
                    end else if (bus.h_rdy) begin
                        bus.h_en  <= 1'b1;
                        bus.h_end <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rleenc_gen.sv
// tb_rleenc_gen: directed bench for rleenc_gen with two instances
// (8x8 blocks and 16-entry blocks), RAM models and a symbol collector.
module tb_rleenc_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rleenc_gen_if #(.WIDTH(16), .LOG2N(6)) b6 ();
    rleenc_gen_if #(.WIDTH(16), .LOG2N(4)) b4 ();

    rleenc_gen #(.WIDTH(16), .LOG2N(6)) u6 (.clk(clk), .reset_n(reset_n), .bus(b6));
    rleenc_gen #(.WIDTH(16), .LOG2N(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    logic en = 1'b0, zz = 1'b0, dc_clr = 1'b0, hr = 1'b1;
    int   sel = 0;
    logic signed [15:0] mem6 [64];
    logic signed [15:0] mem4 [16];
    logic signed [15:0] q6, q4;

    assign b6.en     = en & (sel == 0);
    assign b4.en     = en & (sel == 1);
    assign b6.zz     = zz;
    assign b4.zz     = zz;
    assign b6.dc_clr = dc_clr;
    assign b4.dc_clr = dc_clr;
    assign b6.h_rdy  = hr;
    assign b4.h_rdy  = hr;
    assign b6.q      = q6;
    assign b4.q      = q4;

    // synchronous coefficient RAMs
    always @(posedge clk) begin
        q6 <= mem6[b6.addr];
        q4 <= mem4[b4.addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int val; int len; int dc; int eb; int cy; } sym_t;
    sym_t syms[$];
    int gap = 0, cnt = 0, idle_bad = 0, sp_bad = 0, last_cy = -10, en_cyc = 0;

    // collector and h_rdy policy (gap<0: hold low; gap>0: low for gap cycles after each strobe)
    always @(negedge clk) begin : mon
        logic se;
        sym_t s;
        se = (sel == 0) ? b6.h_en : b4.h_en;
        if (se) begin
            if (sel == 0) s = '{int'(b6.h_val), int'(b6.h_len), int'(b6.h_dc), int'(b6.h_end), cyc};
            else          s = '{int'(b4.h_val), int'(b4.h_len), int'(b4.h_dc), int'(b4.h_end), cyc};
            if (cyc - last_cy < 2) sp_bad++;
            last_cy = cyc;
            syms.push_back(s);
        end
        if (!b6.h_en && (b6.h_val != 0 || b6.h_len != 0 || b6.h_dc || b6.h_end)) idle_bad++;
        if (!b4.h_en && (b4.h_val != 0 || b4.h_len != 0 || b4.h_dc || b4.h_end)) idle_bad++;
        if (gap < 0) begin
            hr = 1'b0; cnt = 0;
        end else if (se && gap > 0) begin
            hr = 1'b0; cnt = gap;
        end else if (cnt > 0) begin
            cnt--; hr = (cnt == 0);
        end else begin
            hr = 1'b1;
        end
    end

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic want(input string tag, input int i, input int v, input int l, input int d, input int e);
        if (i < syms.size()) begin
            chk({tag, " val"}, syms[i].val, v);
            chk({tag, " len"}, syms[i].len, l);
            chk({tag, " dc/end"}, syms[i].dc * 2 + syms[i].eb, d * 2 + e);
        end
    endtask

    task automatic run_blk(input int s, input logic z, input logic clr, input int gp);
        int t;
        sel = s; gap = gp; syms.delete();
        t = 0;
        while (cnt != 0 && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        zz = z; dc_clr = clr; en = 1'b1; en_cyc = cyc;
        @(negedge clk);
        en = 1'b0; dc_clr = 1'b0; zz = 1'b0;
        t = 0;
        while (((s == 0) ? b6.rdy : b4.rdy) !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        chk("block done in budget", int'(t < 3000), 1);
    endtask

    task automatic load_ref();
        int rk[12] = '{0, 1, 3, 4, 5, 6, 7, 9, 12, 14, 18, 20};
        int rq[12] = '{-25, -1, -3, -1, -5, 2, -3, -2, 4, 2, 2, -1};
        for (int i = 0; i < 64; i++) mem6[i] = '0;
        for (int i = 0; i < 12; i++) mem6[rk[i]] = 16'(rq[i]);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int rv[11] = '{-1, -3, -1, -5, 2, -3, -2, 4, 2, 2, -1};
        int rl[11] = '{0, 1, 0, 0, 0, 0, 1, 2, 1, 3, 1};
        for (int i = 0; i < 64; i++) mem6[i] = '0;
        for (int i = 0; i < 16; i++) mem4[i] = '0;
        repeat (3) @(negedge clk);

        chk("reset rdy", b6.rdy, 1);
        chk("reset addr", b6.addr, 0);
        chk("reset h_en", b6.h_en, 0);
        chk("reset h_val", b6.h_val, 0);
        chk("reset h_len", b6.h_len, 0);
        chk("reset h_dc", b6.h_dc, 0);
        chk("reset h_end", b6.h_end, 0);
        chk("reset rdy n16", b4.rdy, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // reference block, raster, consumer back 4 cycles after each strobe
        load_ref();
        run_blk(0, 1'b0, 1'b1, 4);
        chk("ref nsym", syms.size(), 13);
        want("ref dc", 0, -25, 0, 1, 0);
        for (int i = 0; i < 11; i++) want($sformatf("ref ac%0d", i), i + 1, rv[i], rl[i], 0, 0);
        want("ref end", 12, 0, 0, 0, 1);
        if (syms.size() > 0) chk("ref dc latency", syms[0].cy - en_cyc, 3);
        chk("ref rdy", b6.rdy, 1);

        // all-zero block, consumer always ready
        for (int i = 0; i < 64; i++) mem6[i] = '0;
        run_blk(0, 1'b0, 1'b1, 0);
        chk("zero nsym", syms.size(), 2);
        want("zero dc", 0, 0, 0, 1, 0);
        want("zero end", 1, 0, 0, 0, 1);
        if (syms.size() == 2) chk("zero end latency", syms[1].cy - en_cyc, 68);

        // N=16, only the last coefficient set
        mem4[15] = 16'sd7;
        run_blk(1, 1'b0, 1'b1, 0);
        chk("last nsym", syms.size(), 3);
        want("last dc", 0, 0, 0, 1, 0);
        want("last ac", 1, 7, 14, 0, 0);
        want("last end", 2, 0, 0, 0, 1);
        if (syms.size() == 3) chk("last end latency", syms[2].cy - en_cyc, 21);

        // zigzag versus raster with q[8]=5
        for (int i = 0; i < 64; i++) mem6[i] = '0;
        mem6[8] = 16'sd5;
        run_blk(0, 1'b1, 1'b1, 0);
        chk("zz nsym", syms.size(), 3);
        want("zz dc", 0, 0, 0, 1, 0);
        want("zz ac", 1, 5, 1, 0, 0);
        want("zz end", 2, 0, 0, 0, 1);
        run_blk(0, 1'b0, 1'b1, 0);
        chk("raster nsym", syms.size(), 3);
        want("raster ac", 1, 5, 7, 0, 0);

        // DC prediction sequence: DC 10, DC 4, clear, DC 4
        for (int i = 0; i < 64; i++) mem6[i] = '0;
        mem6[0] = 16'sd10;
        run_blk(0, 1'b0, 1'b1, 0);
        want("dcp first", 0, 10, 0, 1, 0);
        mem6[0] = 16'sd4;
        run_blk(0, 1'b0, 1'b0, 0);
`ifdef RLEENC_DCPRED_EN
        want("dcp second", 0, -6, 0, 1, 0);
`else
        want("dcp second", 0, 4, 0, 1, 0);
`endif
        @(negedge clk); dc_clr = 1'b1;
        @(negedge clk); dc_clr = 1'b0;
        run_blk(0, 1'b0, 1'b0, 0);
        want("dcp cleared", 0, 4, 0, 1, 0);

        // reset while the DC symbol is stalled in EMIT
        load_ref();
        sel = 0; gap = -1; syms.delete();
        @(negedge clk); dc_clr = 1'b1; en = 1'b1;
        @(negedge clk); en = 1'b0; dc_clr = 1'b0;
        repeat (6) @(negedge clk);
        chk("stall no strobe", syms.size(), 0);
        chk("stall addr", b6.addr, 1);
        chk("stall busy", b6.rdy, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst rdy", b6.rdy, 1);
        chk("async rst addr", b6.addr, 0);
        chk("async rst h_en", b6.h_en, 0);
        chk("async rst h_val", b6.h_val, 0);
        chk("async rst h_len", b6.h_len, 0);
        chk("async rst flags", {b6.h_dc, b6.h_end}, 0);
        @(negedge clk); reset_n = 1'b1;
        run_blk(0, 1'b0, 1'b1, 4);
        chk("restart nsym", syms.size(), 13);
        want("restart dc", 0, -25, 0, 1, 0);
        want("restart end", 12, 0, 0, 0, 1);

        chk("outputs zero without strobe", idle_bad, 0);
        chk("strobe spacing", sp_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
